// File: rtl/pwm_seq_ctrl.sv
// Sequence controller for the n-bit PWM generator: steps through a table of
// PWM configurations, requesting shadow reloads on period boundaries.
module pwm_seq_ctrl #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int RW    = 8
) (
    input  logic                pwm_clk,
    input  logic                sys_rst_n,
    input  logic                seq_en,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    input  logic [AW-1:0]       last_step,
    input  logic                tbl_we,
    input  logic [AW-1:0]       tbl_addr,
    input  logic [4*N+RW-1:0]   tbl_wdata,
    input  logic                pr_match,
    output logic [2*N-1:0]      cfg0,
    output logic [2*N-1:0]      cfg1,
    output logic                ld_trg,
    output logic                busy,
    output logic [AW-1:0]       step,
    output logic                done,
    output logic                step_evt
);

    localparam int TW = 4*N + RW;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Table word layout is {rep, pr, dc, ph, of}.
    function automatic logic [RW-1:0] f_rep(input logic [TW-1:0] word);
        return word[TW-1 -: RW];
    endfunction

    function automatic logic [2*N-1:0] f_cfg0(input logic [TW-1:0] word);
        return word[4*N-1 -: 2*N];
    endfunction

    function automatic logic [2*N-1:0] f_cfg1(input logic [TW-1:0] word);
        return word[2*N-1:0];
    endfunction

    logic [TW-1:0]   tbl_r [DEPTH];
    state_t          state_r;
    logic [AW-1:0]   nxt_r;
    logic [AW-1:0]   step_r;
    logic [RW-1:0]   rep_hold_r;
    logic [RW-1:0]   rpt_cnt_r;
    logic [2*N-1:0]  cfg0_r;
    logic [2*N-1:0]  cfg1_r;
    logic            ld_trg_r;
    logic            busy_r;
    logic            done_r;
    logic            step_evt_r;

    logic [TW-1:0]   fetch_s;
    logic            abort_s;
    logic            is_last_s;

    assign fetch_s   = tbl_r[nxt_r];
    assign abort_s   = stop | ~seq_en;
    // A step beyond last_step (after a live change) is treated as the last one.
    assign is_last_s = (step_r >= last_step);

    // Configuration table; a same-cycle fetch sees the pre-write contents.
    always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_r[i] <= {TW{1'b0}};
            end
        end else if (tbl_we) begin
            tbl_r[tbl_addr] <= tbl_wdata;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            nxt_r      <= {AW{1'b0}};
            step_r     <= {AW{1'b0}};
            rep_hold_r <= {RW{1'b0}};
            rpt_cnt_r  <= {RW{1'b0}};
            cfg0_r     <= {(2*N){1'b0}};
            cfg1_r     <= {(2*N){1'b0}};
            ld_trg_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            step_evt_r <= 1'b0;
        end else begin
            step_evt_r <= 1'b0;
            done_r     <= 1'b0;
            if (abort_s) begin
                // Abort keeps cfg/step so the PWM continues with what it has.
                state_r  <= ST_IDLE;
                ld_trg_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        ld_trg_r <= 1'b0;
                        busy_r   <= 1'b0;
                        if (start) begin
                            nxt_r   <= {AW{1'b0}};
                            busy_r  <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        cfg0_r     <= f_cfg0(fetch_s);
                        cfg1_r     <= f_cfg1(fetch_s);
                        rep_hold_r <= f_rep(fetch_s);
                        ld_trg_r   <= 1'b1;
                        state_r    <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (pr_match) begin
                            ld_trg_r   <= 1'b0;
                            step_r     <= nxt_r;
                            rpt_cnt_r  <= rep_hold_r;
                            step_evt_r <= 1'b1;
                            state_r    <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // Prefetch as soon as repeats run out so the next entry
                        // is armed before the boundary that ends this step.
                        if (rpt_cnt_r != {RW{1'b0}}) begin
                            if (pr_match) begin
                                rpt_cnt_r <= rpt_cnt_r - {{(RW-1){1'b0}}, 1'b1};
                            end
                        end else if (!is_last_s) begin
                            nxt_r   <= step_r + {{(AW-1){1'b0}}, 1'b1};
                            state_r <= ST_FETCH;
                        end else if (loop) begin
                            nxt_r   <= {AW{1'b0}};
                            state_r <= ST_FETCH;
                        end else if (pr_match) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        ld_trg_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg0     = cfg0_r;
    assign cfg1     = cfg1_r;
    assign ld_trg   = ld_trg_r;
    assign busy     = busy_r;
    assign step     = step_r;
    assign done     = done_r;
    assign step_evt = step_evt_r;

endmodule
